ssd_scan_ctrl: RTL and testbench

Parametrised N-digit seven-segment scan controller for the Nexys-class SSD bank. It replaces the ad-hoc top-level scan and hex-decode logic. Adds:
- configurable digit count and scan rate
- per-digit enable and decimal point
- leading-zero suppression
- 16-level PWM brightness
- tear-free, frame-synchronous display updates
It sits in the top level between game logic (which supplies hex values) and the An*/Ca..Cg/Dp pins.

---
 rtl/ssd_scan_ctrl_pkg.sv | 33 +++
 rtl/ssd_hex_decoder.sv | 33 +++
 rtl/ssd_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared seven-segment definitions: segment patterns, blank pattern and the
// cathode bus bit order. Imported by the hex decoder and the scan controller.
package ssd_scan_ctrl_pkg;

  // Segment vector order is {a,b,c,d,e,f,g}; all patterns are active low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Cathode bus is {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}: segments on the top seven bits,
  // decimal point in bit 0.
  localparam int CATH_SEG_MSB = 7;
  localparam int CATH_SEG_LSB = 1;
  localparam int CATH_DP      = 0;
  localparam logic [7:0] CATH_OFF = 8'hFF;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module ssd_hex_decoder
  import ssd_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  // Straight table lookup of the glyph for each hex value.
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller: prescaled digit scan, frame-synchronous
// staging->shadow update, enable/leading-zero blanking, 16-level PWM brightness.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              cathodes,
  output logic [2:0]              scan_idx,
  output logic                    frame_done
);

  logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
  logic [2:0]               scan_q, scan_d;
  logic                     frame_done_q;
  logic                     slot_end, frame_wrap;

  logic [4*NUM_DIGITS-1:0]  stg_dig_q, sh_dig_q;
  logic [NUM_DIGITS-1:0]    stg_dp_q, stg_en_q, sh_dp_q, sh_en_q;
  logic                     pending_q;

  logic [3:0]               cur_dig, pwm_phase;
  logic                     cur_dp, cur_en, lead_zero, blank, pwm_on, lit;
  seg_t                     seg;

  logic [NUM_DIGITS-1:0]    an_d, an_q;
  logic [7:0]               cath_d, cath_q;

  assign slot_end   = &presc_q;
  assign frame_wrap = slot_end && (scan_q == 3'(NUM_DIGITS - 1));
  assign presc_d    = presc_q + SCAN_DIV_BITS'(1);

  // Next digit index: advance at the end of each slot, wrap after the last digit.
  always_comb begin
    scan_d = scan_q;
    if (slot_end) scan_d = frame_wrap ? 3'd0 : scan_q + 3'd1;
  end

  // Prescaler, scan counter and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      scan_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      scan_q       <= scan_d;
      frame_done_q <= frame_wrap;
    end
  end

  // Staging/shadow update; shadow only moves at the frame wrap so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_dig_q <= '0;
      stg_dp_q  <= '0;
      stg_en_q  <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (load) begin
        stg_dig_q <= digits_in;
        stg_dp_q  <= dp_in;
        stg_en_q  <= en_in;
      end
      if (frame_wrap) begin
        // A load coinciding with the wrap bypasses staging so it is not a frame late.
        if (load) begin
          sh_dig_q <= digits_in;
          sh_dp_q  <= dp_in;
          sh_en_q  <= en_in;
        end else if (pending_q) begin
          sh_dig_q <= stg_dig_q;
          sh_dp_q  <= stg_dp_q;
          sh_en_q  <= stg_en_q;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Select the current digit and detect whether it and everything left of it is zero.
  always_comb begin
    cur_dig   = '0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == 3'(i)) begin
        cur_dig = sh_dig_q[4*i +: 4];
        cur_dp  = sh_dp_q[i];
        cur_en  = sh_en_q[i];
      end
      if ((3'(i) >= scan_q) && (sh_dig_q[4*i +: 4] != 4'h0)) lead_zero = 1'b0;
    end
  end

  ssd_hex_decoder u_hex_decoder (
    .hex_i (cur_dig),
    .seg_o (seg)
  );

  assign pwm_phase = presc_q[SCAN_DIV_BITS-1 -: 4];
  assign blank     = !cur_en || (lz_suppress && (scan_q != 3'd0) && lead_zero) ||
                     (brightness == 4'd0);
  assign pwm_on    = (brightness == 4'hF) || (pwm_phase < brightness);
  assign lit       = !blank && pwm_on;

  // Next anode/cathode values; cathodes are also released during PWM off-time so
  // no segment is driven while its anode is off.
  always_comb begin
    an_d   = '1;
    cath_d = CATH_OFF;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (scan_q == 3'(i)) an_d[i] = 1'b0;
      end
      cath_d[CATH_SEG_MSB:CATH_SEG_LSB] = seg;
      cath_d[CATH_DP]                   = ~cur_dp;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '1;
      cath_q <= CATH_OFF;
    end else begin
      an_q   <= an_d;
      cath_q <= cath_d;
    end
  end

  assign an         = an_q;
  assign cathodes   = cath_q;
  assign scan_idx   = scan_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with NUM_DIGITS=4, SCAN_DIV_BITS=4.
module tb_ssd_scan_ctrl;

  localparam int ND  = 4;
  localparam int SDB = 4;
  localparam int SLOT  = 1 << SDB;
  localparam int FRAME = SLOT * ND;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] en_in = '0;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [3:0]    brightness = 4'd0;
  logic [ND-1:0] an;
  logic [7:0]    cathodes;
  logic [2:0]    scan_idx;
  logic          frame_done;

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .en_in(en_in),
    .load(load), .lz_suppress(lz_suppress), .brightness(brightness),
    .an(an), .cathodes(cathodes), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [7:0]    cath;
    logic [2:0]    idx;
    logic          fd;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: a cycle count since reset plus shadow/staging digit arrays.
  int       m_tick = 0;
  bit       m_live = 0;
  bit       m_pend;
  bit [3:0] sh_dig[ND], st_dig[ND];
  bit       sh_dp[ND], sh_en[ND], st_dp[ND], st_en[ND];

  function automatic logic [6:0] glyph(input bit [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Model: predicts the outputs visible after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    int slot, phase, pwm;
    bit lead, dark, wrap;
    logic [ND-1:0] onehot;
    if (rst) begin
      m_live = 1;
      m_tick = 0;
      m_pend = 0;
      for (int j = 0; j < ND; j++) begin
        sh_dig[j] = 0; st_dig[j] = 0; sh_dp[j] = 0; sh_en[j] = 0; st_dp[j] = 0; st_en[j] = 0;
      end
      e.an = '1; e.cath = 8'hFF; e.idx = 3'd0; e.fd = 1'b0;
    end else if (m_live) begin
      slot  = (m_tick / SLOT) % ND;
      phase = m_tick % SLOT;
      pwm   = phase >> (SDB - 4);
      lead  = 1;
      for (int j = slot; j < ND; j++) if (sh_dig[j] != 0) lead = 0;
      dark = !sh_en[slot] || (lz_suppress && slot != 0 && lead) || brightness == 0 ||
             !(brightness == 15 || pwm < int'(brightness));
      onehot = ND'(1) << slot;
      e.an   = dark ? '1 : ~onehot;
      e.cath = dark ? 8'hFF : {glyph(sh_dig[slot]), ~sh_dp[slot]};
      wrap   = (m_tick % FRAME) == FRAME - 1;
      e.fd   = wrap;
      if (wrap && load) begin
        for (int j = 0; j < ND; j++) begin
          sh_dig[j] = digits_in[4*j +: 4]; sh_dp[j] = dp_in[j]; sh_en[j] = en_in[j];
        end
        m_pend = 0;
      end else if (wrap && m_pend) begin
        sh_dig = st_dig; sh_dp = st_dp; sh_en = st_en;
        m_pend = 0;
      end
      if (load) begin
        for (int j = 0; j < ND; j++) begin
          st_dig[j] = digits_in[4*j +: 4]; st_dp[j] = dp_in[j]; st_en[j] = en_in[j];
        end
        if (!wrap) m_pend = 1;
      end
      m_tick++;
      e.idx = 3'((m_tick / SLOT) % ND);
    end
    if (m_live) exp_q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: pops one prediction per cycle and compares it against the pins.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an", int'(an), int'(e.an));
      chk("cathodes", int'(cathodes), int'(e.cath));
      chk("scan_idx", int'(scan_idx), int'(e.idx));
      chk("frame_done", int'(frame_done), int'(e.fd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] dp,
                         input logic [ND-1:0] en);
    digits_in = d; dp_in = dp; en_in = en; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  // Wait (bounded) until the next rising edge lands on the given frame position.
  task automatic wait_pos(input int pos, input string name);
    for (int k = 0; k < 3 * FRAME; k++) begin
      if ((m_tick % FRAME) == pos) return;
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: frame position %0d not reached, at %0d", name, pos, m_tick % FRAME);
  endtask

  initial begin
    // 1: reset then idle, nothing lit
    cyc(3);
    rst = 1'b0;
    cyc(2 * FRAME + 10);

    // 2: mid-frame load at full brightness
    brightness = 4'd15;
    wait_pos(20, "t2_pos");
    do_load(16'h12AF, 4'b0100, 4'hF);
    cyc(2 * FRAME + 5);

    // 3: leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0050, 4'b0000, 4'hF);
    cyc(2 * FRAME);
    do_load(16'h0000, 4'b0000, 4'hF);
    cyc(2 * FRAME);

    // 4: PWM duty and dark
    lz_suppress = 1'b0;
    brightness  = 4'd4;
    do_load(16'h0007, 4'b0001, 4'b0001);
    cyc(2 * FRAME);
    brightness = 4'd0;
    cyc(FRAME);

    // 5: load on the wrap cycle, second load two cycles later
    brightness = 4'd15;
    wait_pos(FRAME - 1, "t5_pos");
    digits_in = 16'h8888; en_in = 4'hF; dp_in = 4'h0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    do_load(16'h1111, 4'h0, 4'hF);
    cyc(3 * FRAME);

    // 6: reset while digit 2 is scanning with a pending load
    wait_pos(2 * SLOT + 3, "t6_pos");
    do_load(16'h3C3C, 4'hA, 4'hF);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2 * FRAME);

    // Randomised loads, brightness, suppression and occasional reset
    for (int it = 0; it < 60; it++) begin
      cyc($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) lz_suppress = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        digits_in = 16'($urandom) & 16'($urandom);
        dp_in     = 4'($urandom);
        en_in     = 4'($urandom) | 4'($urandom);
        load      = 1'b1;
        cyc(1);
        load = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    cyc(FRAME);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
